systolic_ctrl: RTL and testbench
================================

# systolic_ctrl

Job sequencer for the output-stationary multi-precision PE array. Per matrix tile it clears the accumulators, paces K input/weight feed beats, and generates the per-row and per-column skewed valid wavefront plus the last marker. It then waits for the wavefront to flush and drains the stationary accumulators out of the array bottom under downstream backpressure. It sits between the job/command front-end and the PE mesh and feed buffers.

## Interface
- ROWS, 4, PE rows in the array (≥1)
- COLS, 4, PE columns in the array (≥1)
- KW, 16, width of the K-length counter
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  job request, sampled only in IDLE
- k_len  in  KW  number of feed beats (packed vectors) for the job
- mode_in  in  2  precision_mode_t for the job (INT4/INT8/INT16)
- abort  in  1  synchronous job cancel
- out_ready  in  1  downstream accepts a drained row this cycle
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at job end
- precision_mode  out  2  mode latched at start, held stable for the whole job
- acc_clear  out  1  array-wide accumulator clear
- drain_enable  out  1  array-wide drain shift
- feed_valid  out  1  feed buffers must present beat feed_k this cycle
- feed_k  out  KW  current feed beat index
- row_valid  out  ROWS  valid_h_in for each row's left edge; bit r = feed_valid delayed r cycles
- col_valid  out  COLS  valid_v_in for each column's top edge; bit c = feed_valid delayed c cycles
- row_last  out  ROWS  last_in per row; bit r = the last-beat flag delayed r cycles
- out_valid  out  1  bottom-row accumulators are valid on the array's bottom bus
- out_row  out  $clog2(ROWS) (min 1)  index of the row being drained

## Operation
- States: IDLE, CLEAR, FEED, FLUSH, DRAIN, DONE.
- IDLE: on start with k_len≠0, latch k_len and mode_in, then go to CLEAR. On start with k_len=0, go to DONE directly; no clear, feed or drain activity occurs. start is ignored outside IDLE.
- CLEAR: a single cycle with acc_clear=1, then go to FEED.
- FEED: lasts exactly k_len cycles with feed_valid=1 and feed_k=0…k_len-1. The last-beat flag is 1 only while feed_k=k_len-1. Then go to FLUSH.
- FLUSH: lasts ROWS+COLS cycles with all controls low, letting the skew and latch pipeline empty, then go to DRAIN.
- DRAIN: a row counter starts at 0.
  - drain_enable = out_valid = out_ready.
  - out_row = ROWS-1-counter.
  - The counter increments on each accepted beat. After ROWS accepted beats, go to DONE.
  - When out_ready=0, drain_enable stays low and the array holds its data, because all valid bits are 0.
- DONE: a single cycle with done=1, then go to IDLE.
- Skew delay lines run in every state. Row 0 and column 0 are undelayed copies of feed_valid and the last-beat flag.
- abort in any non-IDLE state:
  - next state is IDLE;
  - all skew registers clear;
  - acc_clear=1 for that one cycle;
  - done is not pulsed.
  - abort in IDLE is ignored.
  - abort and start in the same IDLE cycle: start wins.
- The feed_k counter does not wrap. k_len = 2^KW-1 is the maximum.

## Timing
- Reset values: every output 0, precision_mode = MODE_INT16, state = IDLE, all skew registers 0. A reset asserted mid-job returns the block to this state immediately; there is no done pulse.
- Cycle numbering: with start sampled at cycle 0 and K=k_len:
  - CLEAR at cycle 1;
  - FEED at cycles 2…K+1;
  - FLUSH at cycles K+2…K+ROWS+COLS+1;
  - the first DRAIN cycle is K+ROWS+COLS+2.
- With out_ready held high, done is at cycle K+2·ROWS+COLS+2. Each out_ready=0 drain cycle adds one cycle.
- The earliest next start is the cycle after done, once the block is back in IDLE.
- row_valid[r] is high on cycles 2+r…K+1+r. row_last[r] is high on cycle K+1+r only.

## Configuration
- SYSTOLIC_CTRL_PERF_EN defined: adds two 32-bit outputs, perf_cycles and perf_stalls.
  - perf_cycles counts busy cycles of the current or last job.
  - perf_stalls counts DRAIN cycles with out_ready=0.
  - Both counters clear when a job leaves IDLE, saturate at 2^32-1, and hold after done.
- Undefined: these ports and counters are absent. All other behaviour is identical.

## Test plan
- ROWS=COLS=4, K=3, out_ready=1 → acc_clear at cycle 1; feed_k 0,1,2 at cycles 2–4; row_valid[3] at cycles 5–7; out_valid at cycles 13–16 with out_row 3,2,1,0; done at cycle 17.
- Same job with out_ready low on two drain cycles → drain_enable=0 on those cycles; done at cycle 19; perf_stalls=2 when SYSTOLIC_CTRL_PERF_EN is defined.
- start with k_len=0 → done at cycle 1; acc_clear, feed_valid and out_valid never assert.
- abort asserted at cycle 3 (during FEED) → acc_clear=1 at cycle 3; IDLE at cycle 4; no done pulse; all row_valid and col_valid 0 by cycle 4.
- rst asserted during DRAIN → all outputs 0 asynchronously; after release, a new start of K=1 completes with done at cycle 1+2·4+4+2 = 15.
- mode_in=INT4 at start, then mode_in changed to INT8 mid-job → precision_mode stays INT4 until IDLE.

Source files
------------

// File: rtl/systolic_ctrl_if.sv
// Job/array control bundle between the job front-end, systolic_ctrl and the PE mesh.
// master = front-end and drain sink (drives start/k_len/mode_in/abort/out_ready); slave = systolic_ctrl.
// perf_cycles/perf_stalls exist only when SYSTOLIC_CTRL_PERF_EN is defined.
interface systolic_ctrl_if #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int KW   = 16
);
  localparam int ORW = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic            start;
  logic [KW-1:0]   k_len;
  logic [1:0]      mode_in;
  logic            abort;
  logic            out_ready;

  logic            busy;
  logic            done;
  logic [1:0]      precision_mode;
  logic            acc_clear;
  logic            drain_enable;
  logic            feed_valid;
  logic [KW-1:0]   feed_k;
  logic [ROWS-1:0] row_valid;
  logic [COLS-1:0] col_valid;
  logic [ROWS-1:0] row_last;
  logic            out_valid;
  logic [ORW-1:0]  out_row;
`ifdef SYSTOLIC_CTRL_PERF_EN
  logic [31:0]     perf_cycles;
  logic [31:0]     perf_stalls;
`endif

  modport master (
    output start, k_len, mode_in, abort, out_ready,
`ifdef SYSTOLIC_CTRL_PERF_EN
    input  perf_cycles, perf_stalls,
`endif
    input  busy, done, precision_mode, acc_clear, drain_enable, feed_valid,
           feed_k, row_valid, col_valid, row_last, out_valid, out_row
  );

  modport slave (
    input  start, k_len, mode_in, abort, out_ready,
`ifdef SYSTOLIC_CTRL_PERF_EN
    output perf_cycles, perf_stalls,
`endif
    output busy, done, precision_mode, acc_clear, drain_enable, feed_valid,
           feed_k, row_valid, col_valid, row_last, out_valid, out_row
  );
endinterface

// File: rtl/systolic_ctrl.sv
// Tile sequencer for the output-stationary PE array: clear, K feed beats with skewed valid/last, flush, drain.
// Latency: CLEAR 1 cycle after start, done at K+2*ROWS+COLS+2 with out_ready high; k_len=0 gives done at cycle 1.
// Backpressure: drain stalls (drain_enable/out_valid low) while out_ready=0; SYSTOLIC_CTRL_PERF_EN adds perf counters.
module systolic_ctrl #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int KW   = 16
) (
  input  logic           clk,
  input  logic           rst,
  systolic_ctrl_if.slave bus
);
  localparam int ORW = (ROWS > 1) ? $clog2(ROWS) : 1;
  // Skew depth needed by the wider edge of the array; row/col 0 are taken straight from the feed.
  localparam int SKD = ((ROWS > COLS) ? ROWS : COLS) - 1;
  localparam int SRW = (SKD > 0) ? SKD : 1;
  localparam logic [1:0]    MODE_INT16 = 2'd2;
  localparam logic [KW-1:0] FLUSH_LAST = KW'(ROWS + COLS - 1);
  localparam logic [KW-1:0] DRAIN_LAST = KW'(ROWS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_FEED, S_FLUSH, S_DRAIN, S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [KW-1:0]   r_cnt;
  logic [KW-1:0]   r_klen;
  logic [1:0]      r_mode;
  logic [SRW-1:0]  r_vld_sr;
  logic [SRW-1:0]  r_last_sr;
  logic [SRW:0]    w_vld_tap;
  logic [SRW:0]    w_last_tap;
  logic            w_abort;
  logic            w_acc_clear;
  logic            w_feed_valid;
  logic            w_feed_last;
  logic            w_drain;
  logic            w_done;

  // abort only means something once a job is running; in IDLE start takes priority
  assign w_abort = bus.abort && (r_state != S_IDLE);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode and per-state array controls; abort overrides everything
  always_comb begin
    w_next       = r_state;
    w_acc_clear  = 1'b0;
    w_feed_valid = 1'b0;
    w_drain      = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = (bus.k_len == '0) ? S_DONE : S_CLEAR;
      S_CLEAR: begin
        w_acc_clear = 1'b1;
        w_next      = S_FEED;
      end
      S_FEED: begin
        w_feed_valid = 1'b1;
        if (r_cnt == r_klen - KW'(1)) w_next = S_FLUSH;
      end
      S_FLUSH: if (r_cnt == FLUSH_LAST) w_next = S_DRAIN;
      S_DRAIN: begin
        w_drain = bus.out_ready;
        if (bus.out_ready && (r_cnt == DRAIN_LAST)) w_next = S_DONE;
      end
      S_DONE: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (w_abort) begin
      w_next       = S_IDLE;
      w_acc_clear  = 1'b1;
      w_feed_valid = 1'b0;
      w_drain      = 1'b0;
      w_done       = 1'b0;
    end
  end

  assign w_feed_last = w_feed_valid && (r_cnt == r_klen - KW'(1));

  // One counter serves as feed beat index, flush timer and drained-row count; it restarts on every state change
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                               r_cnt <= '0;
    else if (w_next != r_state)                            r_cnt <= '0;
    else if (w_feed_valid || (r_state == S_FLUSH) || w_drain) r_cnt <= r_cnt + KW'(1);
  end

  // Job parameters are captured on acceptance so mode_in/k_len may change freely mid-job
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_klen <= '0;
      r_mode <= MODE_INT16;
    end else if ((r_state == S_IDLE) && bus.start) begin
      r_klen <= bus.k_len;
      r_mode <= bus.mode_in;
    end
  end

  // Skew delay lines run every cycle; tap i is the feed signal delayed i cycles
  assign w_vld_tap  = {r_vld_sr, w_feed_valid};
  assign w_last_tap = {r_last_sr, w_feed_last};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_sr  <= '0;
      r_last_sr <= '0;
    end else if (w_abort) begin
      r_vld_sr  <= '0;
      r_last_sr <= '0;
    end else begin
      r_vld_sr  <= w_vld_tap[SRW-1:0];
      r_last_sr <= w_last_tap[SRW-1:0];
    end
  end

  assign bus.busy           = (r_state != S_IDLE);
  assign bus.done           = w_done;
  assign bus.precision_mode = r_mode;
  assign bus.acc_clear      = w_acc_clear;
  assign bus.feed_valid     = w_feed_valid;
  assign bus.feed_k         = w_feed_valid ? r_cnt : '0;
  assign bus.row_valid      = w_vld_tap[ROWS-1:0];
  assign bus.col_valid      = w_vld_tap[COLS-1:0];
  assign bus.row_last       = w_last_tap[ROWS-1:0];
  // Drain and out_valid are the same strobe: the array shifts exactly when the sink takes a row
  assign bus.drain_enable   = w_drain;
  assign bus.out_valid      = w_drain;
  // Bottom row leaves first, so the index counts down from ROWS-1
  assign bus.out_row        = (r_state == S_DRAIN) ? (ORW'(ROWS - 1) - r_cnt[ORW-1:0]) : '0;

`ifdef SYSTOLIC_CTRL_PERF_EN
  logic [31:0] r_perf_cycles;
  logic [31:0] r_perf_stalls;

  // Busy-cycle and drain-stall counters, restarted on job acceptance, saturating, held after the job
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_cycles <= '0;
      r_perf_stalls <= '0;
    end else if ((r_state == S_IDLE) && bus.start) begin
      r_perf_cycles <= '0;
      r_perf_stalls <= '0;
    end else begin
      if ((r_state != S_IDLE) && (r_perf_cycles != '1))
        r_perf_cycles <= r_perf_cycles + 32'd1;
      if ((r_state == S_DRAIN) && !bus.out_ready && (r_perf_stalls != '1))
        r_perf_stalls <= r_perf_stalls + 32'd1;
    end
  end

  assign bus.perf_cycles = r_perf_cycles;
  assign bus.perf_stalls = r_perf_stalls;
`endif
endmodule

// File: tb/tb_systolic_ctrl.sv
// Bench for systolic_ctrl: per-scenario tasks drive jobs and compare every cycle against a timing model.
// The model derives each output from the job's cycle number, K and the chosen out_ready pattern.
// Optional perf counters are checked when SYSTOLIC_CTRL_PERF_EN is defined.
module tb_systolic_ctrl;
  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int KW   = 16;
  localparam int ORW  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int OBW  = 8 + KW + 2 * ROWS + COLS + ORW;
  localparam logic [1:0] INT4  = 2'd0;
  localparam logic [1:0] INT8  = 2'd1;
  localparam logic [1:0] INT16 = 2'd2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [1:0] prev_mode = INT16;

  systolic_ctrl_if #(.ROWS(ROWS), .COLS(COLS), .KW(KW)) bus ();

  systolic_ctrl #(.ROWS(ROWS), .COLS(COLS), .KW(KW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [OBW-1:0] sample();
    return {bus.busy, bus.done, bus.precision_mode, bus.acc_clear, bus.drain_enable,
            bus.feed_valid, bus.out_valid, bus.feed_k, bus.row_valid, bus.col_valid,
            bus.row_last, bus.out_row};
  endfunction

  // One job from start (cycle 0) through `tail` idle cycles after it ends, checked every cycle.
  task automatic run_job(input string name, input int k, input int stall_pct,
                         input logic [7:0] force_lo, input logic [1:0] mode,
                         input int abort_at, input bit abort_with_start, input int tail);
    logic rdy [0:1023];
    int d0, done_c, job_end, end_c, acc, acc_before, stalls;
    logic live, in_drain;
    logic e_busy, e_done, e_acc, e_drain, e_fv, e_ov;
    logic [1:0]      e_pm;
    logic [KW-1:0]   e_fk;
    logic [ROWS-1:0] e_rv, e_rl;
    logic [COLS-1:0] e_cv;
    logic [ORW-1:0]  e_or;
    logic [OBW-1:0]  obs, exp_o;

    d0 = k + ROWS + COLS + 2;
    for (int c = 0; c < 1024; c++) begin
      rdy[c] = ($urandom_range(99) >= stall_pct);
      if (c >= d0 && c < d0 + 8 && force_lo[c - d0]) rdy[c] = 1'b0;
    end
    done_c = -1;
    acc = 0;
    if (k == 0) done_c = 1;
    else begin
      for (int c = d0; c < 1024 && done_c < 0; c++) begin
        if (rdy[c]) begin
          acc++;
          if (acc == ROWS) done_c = c + 1;
        end
      end
    end
    if (done_c < 0) begin
      $display("FAIL %s: model drain window exceeded, got no completion, expected one", name);
      $fatal(1, "model bound exceeded");
    end
    job_end    = (abort_at >= 0) ? abort_at : done_c;
    end_c      = job_end + tail;
    acc_before = 0;
    stalls     = 0;

    for (int c = 0; c <= end_c; c++) begin
      @(posedge clk);
      #1;
      bus.start     = (c == 0);
      bus.k_len     = (c == 0) ? KW'(k) : KW'($urandom);
      bus.mode_in   = (c == 0) ? mode : 2'($urandom);
      bus.abort     = (c == abort_at) || (c == 0 && abort_with_start) ||
                      (c > job_end && $urandom_range(1) == 1);
      bus.out_ready = rdy[c];
      @(negedge clk);
      obs = sample();

      live     = (abort_at < 0) || (c < abort_at);
      in_drain = (k > 0) && (c >= d0) && (c < done_c) && (c <= job_end);
      e_busy   = (c >= 1) && (c <= job_end);
      e_done   = live && (c == done_c);
      e_pm     = (c >= 1) ? mode : prev_mode;
      e_acc    = live && (k > 0) && (c == 1);
      e_fv     = live && (k > 0) && (c >= 2) && (c <= k + 1);
      e_fk     = e_fv ? KW'(c - 2) : '0;
      for (int r = 0; r < ROWS; r++) begin
        e_rv[r] = live && (k > 0) && (c >= 2 + r) && (c <= k + 1 + r);
        e_rl[r] = live && (k > 0) && (c == k + 1 + r);
      end
      for (int q = 0; q < COLS; q++)
        e_cv[q] = live && (k > 0) && (c >= 2 + q) && (c <= k + 1 + q);
      e_ov    = live && in_drain && rdy[c];
      e_drain = e_ov;
      e_or    = (live && in_drain) ? ORW'(ROWS - 1 - acc_before) : '0;

      if (abort_at >= 0 && c == abort_at) begin
        n_checks++;
        if ({bus.busy, bus.acc_clear, bus.done} !== 3'b110) begin
          n_fail++;
          $display("FAIL %s abort_cycle c=%0d: busy/acc_clear/done got %b expected 110",
                   name, c, {bus.busy, bus.acc_clear, bus.done});
        end
      end else begin
        exp_o = {e_busy, e_done, e_pm, e_acc, e_drain, e_fv, e_ov, e_fk, e_rv, e_cv, e_rl, e_or};
        n_checks++;
        if (obs !== exp_o) begin
          n_fail++;
          $display("FAIL %s cycle %0d: outputs got %h expected %h", name, c, obs, exp_o);
        end
      end
`ifdef SYSTOLIC_CTRL_PERF_EN
      if (c == job_end + 1) begin
        n_checks++;
        if (bus.perf_cycles !== 32'(job_end) || bus.perf_stalls !== 32'(stalls)) begin
          n_fail++;
          $display("FAIL %s perf: cycles/stalls got %0d/%0d expected %0d/%0d",
                   name, bus.perf_cycles, bus.perf_stalls, job_end, stalls);
        end
      end
`endif
      if (in_drain && !rdy[c]) stalls++;
      if (in_drain && rdy[c])  acc_before++;
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
    prev_mode = mode;
  endtask

  task automatic test_reset();
    logic [OBW-1:0] exp_o;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.k_len     = '0;
    bus.mode_in   = INT4;
    bus.abort     = 1'b0;
    bus.out_ready = 1'b0;
    exp_o = {1'b0, 1'b0, INT16, {(OBW - 4){1'b0}}};
    repeat (2) @(negedge clk);
    n_checks++;
    if (sample() !== exp_o) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected %h", sample(), exp_o);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (sample() !== exp_o) begin
      n_fail++;
      $display("FAIL idle_after_reset: got %h expected %h", sample(), exp_o);
    end
    prev_mode = INT16;
  endtask

  task automatic test_basic();
    run_job("basic_k3", 3, 0, 8'h00, INT8, -1, 1'b0, 2);
  endtask

  task automatic test_stall();
    run_job("stall_two", 3, 0, 8'b0000_0101, INT16, -1, 1'b0, 1);
  endtask

  task automatic test_zero_len();
    run_job("zero_len", 0, 20, 8'h00, INT4, -1, 1'b0, 1);
  endtask

  task automatic test_abort();
    run_job("abort_feed", 3, 0, 8'h00, INT8, 3, 1'b0, 2);
    run_job("abort_drain", 5, 30, 8'h00, INT4, 5 + ROWS + COLS + 3, 1'b0, 1);
    run_job("start_beats_abort", 2, 0, 8'h00, INT16, -1, 1'b1, 1);
  endtask

  task automatic test_reset_mid_drain();
    logic [OBW-1:0] exp_o;
    exp_o = {1'b0, 1'b0, INT16, {(OBW - 4){1'b0}}};
    for (int c = 0; c <= 14; c++) begin
      @(posedge clk);
      #1;
      bus.start     = (c == 0);
      bus.k_len     = KW'(3);
      bus.mode_in   = INT8;
      bus.abort     = 1'b0;
      bus.out_ready = 1'b1;
    end
    #2;
    n_checks++;
    if ({bus.busy, bus.out_valid} !== 2'b11) begin
      n_fail++;
      $display("FAIL rst_mid_drain_pre: busy/out_valid got %b expected 11", {bus.busy, bus.out_valid});
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (sample() !== exp_o) begin
      n_fail++;
      $display("FAIL rst_mid_drain_async: got %h expected %h", sample(), exp_o);
    end
    @(posedge clk);
    #1;
    rst       = 1'b0;
    bus.start = 1'b0;
    prev_mode = INT16;
    run_job("post_reset_k1", 1, 0, 8'h00, INT8, -1, 1'b0, 1);
  endtask

  task automatic test_mode_hold();
    run_job("mode_hold", 3, 20, 8'h00, INT4, -1, 1'b0, 1);
  endtask

  task automatic test_back_to_back();
    run_job("b2b_a", 2, 0, 8'h00, INT8, -1, 1'b0, 0);
    run_job("b2b_b", 1, 25, 8'h00, INT4, -1, 1'b0, 0);
    run_job("b2b_c", 0, 0, 8'h00, INT16, -1, 1'b0, 0);
    run_job("b2b_d", 4, 0, 8'h00, INT8, -1, 1'b0, 1);
  endtask

  task automatic test_long();
    run_job("long_k300", 300, 10, 8'h00, INT16, -1, 1'b0, 1);
  endtask

  task automatic test_random();
    for (int j = 0; j < 25; j++) begin
      int k, ab, tl, pct;
      bit aws;
      logic [1:0] md;
      k   = $urandom_range(0, 12);
      pct = $urandom_range(0, 50);
      md  = 2'($urandom_range(0, 2));
      aws = ($urandom_range(0, 3) == 0);
      ab  = -1;
      if ($urandom_range(0, 3) == 0)
        ab = $urandom_range(1, (k == 0) ? 1 : k + 2 * ROWS + COLS + 2);
      tl  = (ab >= 0) ? $urandom_range(1, 2) : $urandom_range(0, 2);
      run_job("random", k, pct, 8'h00, md, ab, aws, tl);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_zero_len();
    test_abort();
    test_reset_mid_drain();
    test_mode_hold();
    test_back_to_back();
    test_long();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
